// File: rtl/shared_data_ram_arbiter.sv
// Round-robin arbiter sharing one data BlockRam among NUM_PORTS shader cores.
// Optional contention counter enabled by SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN.
module shared_data_ram_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               run,
    input  logic [NUM_PORTS-1:0]               req,
    input  logic [NUM_PORTS-1:0]               req_write,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0]    req_write_data,
    output logic [NUM_PORTS-1:0]               grant,
    output logic [NUM_PORTS-1:0]               read_valid,
    output logic [WORD_WIDTH-1:0]              read_data,
    output logic [ADDRESS_WIDTH-1:0]           ram_address,
    output logic                               ram_write,
    output logic [WORD_WIDTH-1:0]              ram_write_data,
    input  logic [WORD_WIDTH-1:0]              ram_read_data
`ifdef SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN
    ,
    output logic [15:0]                        contention_count
`endif
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW:0] NP = (PW+1)'(NUM_PORTS);

    logic [PW-1:0]            rr_pointer;
    logic [PW-1:0]            winner;
    logic [PW-1:0]            next_pointer;
    logic [PW:0]              scan;
    logic [PW:0]              winner_inc;
    logic                     found;
    logic                     active;
    logic [ADDRESS_WIDTH-1:0] port_address [NUM_PORTS];
    logic [WORD_WIDTH-1:0]    port_data    [NUM_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_address[i] = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            port_data[i]    = req_write_data[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    // Scan from the farthest offset down so the port nearest rr_pointer wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            scan = {1'b0, rr_pointer} + (PW+1)'(k);
            if (scan >= NP) scan = scan - NP;
            if (req[scan[PW-1:0]]) begin
                found  = 1'b1;
                winner = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        winner_inc   = {1'b0, winner} + 1'b1;
        next_pointer = (winner_inc == NP) ? '0 : winner_inc[PW-1:0];
    end

    // Handshake: req is a level; an access is accepted in exactly the cycle its grant
    // bit is high, and the requester may drop or change its request on the next cycle.
    always_comb begin
        active         = run && !reset && found;
        grant          = '0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_write_data = '0;
        if (active) begin
            grant[winner]  = 1'b1;
            ram_write      = req_write[winner];
            ram_address    = port_address[winner];
            ram_write_data = port_data[winner];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_pointer <= '0;
            read_valid <= '0;
        end else begin
            read_valid <= (active && !req_write[winner]) ? grant : '0;
            if (active) rr_pointer <= next_pointer;
        end
    end

    assign read_data = ram_read_data;

`ifdef SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN
    logic contended;
    assign contended = run && ($countones(req) >= 2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contention_count <= '0;
        end else if (contended && contention_count != 16'hffff) begin
            contention_count <= contention_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shared_data_ram_arbiter.sv
// Randomized bench for shared_data_ram_arbiter against a cycle-level behavioural model.
// Define SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN to also exercise the contention counter.
module tb_shared_data_ram_arbiter;
  localparam int N  = 4;
  localparam int WW = 32;
  localparam int AW = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            run = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*WW-1:0] req_write_data = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    read_valid;
  logic [WW-1:0]   read_data;
  logic [AW-1:0]   ram_address;
  logic            ram_write;
  logic [WW-1:0]   ram_write_data;
  logic [WW-1:0]   ram_read_data = '0;
`ifdef SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN
  logic [15:0]     contention_count;
`endif

  shared_data_ram_arbiter #(.NUM_PORTS(N), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .req(req),
    .req_write(req_write),
    .req_address(req_address),
    .req_write_data(req_write_data),
    .grant(grant),
    .read_valid(read_valid),
    .read_data(read_data),
    .ram_address(ram_address),
    .ram_write(ram_write),
    .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data)
`ifdef SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN
    ,
    .contention_count(contention_count)
`endif
  );

  // clock / reset block
  always #5 clock = ~clock;

  // BlockRam stand-in: word-addressed, registered read
  logic [WW-1:0] ram_mem [64] = '{default: '0};
  always @(posedge clock) begin
    if (ram_write) ram_mem[ram_address[7:2]] <= ram_write_data;
    ram_read_data <= ram_mem[ram_address[7:2]];
  end

  // scoreboard / reference model state
  logic [WW-1:0] model_mem [64] = '{default: '0};
  logic [WW-1:0] exp_q [$];
  int            model_ptr = 0;
  logic [N-1:0]  model_pend_rv = '0;
  int            model_cnt = 0;
  int            vec_count = 0;
  int            err_count = 0;

  task automatic check_equal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver + model step for one clock cycle
  task automatic run_cycle(input logic rst, input logic r, input logic [N-1:0] rq,
                           input logic [N-1:0] wr, input logic [N*AW-1:0] addr,
                           input logic [N*WW-1:0] wd);
    int win;
    int p;
    logic [N-1:0]  exp_grant;
    logic [AW-1:0] exp_addr;
    logic [WW-1:0] exp_wd;
    logic          exp_we;
    logic [N-1:0]  exp_rv;
    logic [WW-1:0] exp_rd;
    @(negedge clock);
    reset = rst; run = r; req = rq; req_write = wr; req_address = addr; req_write_data = wd;
    #1;
    win = -1;
    if (!rst && r) begin
      for (int k = 0; k < N; k++) begin
        p = (model_ptr + k) % N;
        if (rq[p] && win < 0) win = p;
      end
    end
    exp_grant = '0; exp_addr = '0; exp_wd = '0; exp_we = 1'b0;
    if (win >= 0) begin
      exp_grant[win] = 1'b1;
      exp_addr = addr[win*AW +: AW];
      exp_wd   = wd[win*WW +: WW];
      exp_we   = wr[win];
    end
    exp_rv = rst ? '0 : model_pend_rv;
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_equal("grant", 32'(grant), 32'(exp_grant));
    check_equal("ram_write", 32'(ram_write), 32'(exp_we));
    check_equal("ram_address", 32'(ram_address), 32'(exp_addr));
    check_equal("ram_write_data", ram_write_data, exp_wd);
    check_equal("read_valid", 32'(read_valid), 32'(exp_rv));
    if (exp_rv != '0) check_equal("read_data", read_data, exp_rd);
`ifdef SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN
    check_equal("contention_count", 32'(contention_count), rst ? 32'd0 : 32'(model_cnt));
`endif
    if (rst) begin
      model_ptr = 0; model_pend_rv = '0; model_cnt = 0;
      exp_q.delete();
    end else begin
      model_pend_rv = '0;
      if (win >= 0) begin
        model_ptr = (win + 1) % N;
        if (wr[win]) begin
          model_mem[exp_addr[7:2]] = exp_wd;
        end else begin
          model_pend_rv[win] = 1'b1;
          exp_q.push_back(model_mem[exp_addr[7:2]]);
        end
      end
      if (r && $countones(rq) >= 2 && model_cnt < 65535) model_cnt++;
    end
  endtask

  function automatic logic [N*AW-1:0] rand_addr();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'({$urandom_range(0, 63), 2'b00});
    return a;
  endfunction

  function automatic logic [N*WW-1:0] rand_data();
    logic [N*WW-1:0] d;
    for (int i = 0; i < N; i++) d[i*WW +: WW] = $urandom;
    return d;
  endfunction

  logic [N*AW-1:0] a_fix;
  logic [N*WW-1:0] d_fix;

  initial begin
    // reset held with all ports requesting, then release
    run_cycle(1'b1, 1'b1, 4'b1111, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b1, 1'b1, 4'b1111, 4'b0000, rand_addr(), rand_data());
    // rotation with all ports reading
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 4'b1111, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b1, 4'b0000, 4'b0000, '0, '0);

    // write then read-back through another port
    a_fix = '0; d_fix = '0;
    a_fix[2*AW +: AW] = 16'h0010;
    a_fix[0 +: AW]    = 16'h0010;
    d_fix[2*WW +: WW] = 32'hcafef00d;
    run_cycle(1'b0, 1'b1, 4'b0100, 4'b0100, a_fix, d_fix);
    run_cycle(1'b0, 1'b1, 4'b0001, 4'b0000, a_fix, d_fix);
    run_cycle(1'b0, 1'b1, 4'b0000, 4'b0000, a_fix, d_fix);
    check_equal("rd_cafef00d", model_mem[4], 32'(ram_mem[4]));

    // pointer at 3 with requests on 0 and 2
    run_cycle(1'b0, 1'b1, 4'b0100, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b1, 4'b0101, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b1, 4'b0101, 4'b0000, rand_addr(), rand_data());

    // run drops after a read grant, then reset in the return cycle
    run_cycle(1'b0, 1'b1, 4'b0001, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b0, 4'b1111, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b0, 4'b1111, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b1, 4'b0010, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b1, 1'b0, 4'b1111, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b0, 4'b0000, 4'b0000, rand_addr(), rand_data());
    run_cycle(1'b0, 1'b1, 4'b1111, 4'b0000, rand_addr(), rand_data());

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                N'($urandom), N'($urandom), rand_addr(), rand_data());
    end

`ifdef SHARED_DATA_RAM_ARB_CONTENTION_COUNT_EN
    // saturation of the contention counter
    run_cycle(1'b1, 1'b0, 4'b0000, 4'b0000, '0, '0);
    for (int i = 0; i < 70000; i++) run_cycle(1'b0, 1'b1, 4'b0011, 4'b0000, '0, '0);
    check_equal("count_saturated", 32'(contention_count), 32'h0000ffff);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 4'b0001, 4'b0000, '0, '0);
    check_equal("count_held", 32'(contention_count), 32'h0000ffff);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
